// File: rtl/bcd_countdown_timer_pkg.sv
// timer_pkg: shared types and constants for the BCD countdown timer
//   bcd_t        one BCD digit
//   tmr_state_t  IDLE / RUN / PAUSE / DONE
//   bcd_sat()    clamps every digit of a 4-digit BCD word to 9
package timer_pkg;
    typedef logic [3:0] bcd_t;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} tmr_state_t;
    localparam bcd_t BCD_MAX = 4'd9;
    localparam logic [15:0] TIME_ZERO = 16'h0000;
    function automatic logic [15:0] bcd_sat(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
            r[i*4 +: 4] = (v[i*4 +: 4] > BCD_MAX) ? BCD_MAX : v[i*4 +: 4];
        return r;
    endfunction
endpackage

// File: rtl/bcd_countdown_timer_dec_digit.sv
// bcd_dec_digit: one BCD digit of the decrement borrow chain
//   digit_i   current digit
//   borrow_i  decrement request from the less significant digit
//   digit_o   digit after the optional decrement (0 wraps to 9)
//   borrow_o  borrow passed to the more significant digit
module bcd_dec_digit
    import timer_pkg::*;
(
    input  bcd_t digit_i,
    input  logic borrow_i,
    output bcd_t digit_o,
    output logic borrow_o
);
    assign borrow_o = borrow_i && (digit_i == 4'd0);
    assign digit_o  = !borrow_i ? digit_i : (digit_i == 4'd0) ? BCD_MAX : digit_i - 4'd1;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: BCD SS.hh countdown with prescaled 1/100 s ticks and expiry flag
//   clk, rst   clock, asynchronous active-high reset
//   load       capture saturated preset, return to IDLE
//   preset     BCD {sec_tens, sec_ones, hund_tens, hund_ones}
//   start/stop begin-resume / pause counting (stop wins)
//   time_bcd   current count
//   running    high while in RUN
//   expired    expiry indication
// Optional feature macro AUTO_RELOAD_EN: on expiry reload the last preset and keep running,
// with expired as a one-cycle pulse; without it expiry parks in DONE with expired held.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int PRESCALE = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        expired
);
    localparam int PW = $clog2(PRESCALE);

    tmr_state_t    state_q;
    logic [15:0]   cnt_q;
    logic [15:0]   dec_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          running_q;
    logic          expired_q;
    logic [4:0]    brw;
    logic          tick;
    logic          hit_zero;
`ifdef AUTO_RELOAD_EN
    logic [15:0]   shadow_q;
`endif

    // brw[4] set means the count is already 0000; it blocks any decrement below zero
    assign brw[0] = 1'b1;
    bcd_dec_digit u_dig [3:0] (
        .digit_i (cnt_q),
        .borrow_i(brw[3:0]),
        .digit_o (dec_d),
        .borrow_o(brw[4:1])
    );

    assign tick     = (presc_q == PW'(PRESCALE - 1)) && !brw[4];
    assign presc_d  = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + 1'b1;
    assign hit_zero = (dec_d == TIME_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= TIME_ZERO;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
            shadow_q  <= TIME_ZERO;
`endif
        end else if (load) begin
            state_q   <= IDLE;
            cnt_q     <= bcd_sat(preset);
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
            shadow_q  <= bcd_sat(preset);
`endif
        end else begin
`ifdef AUTO_RELOAD_EN
            // reload expiry is a pulse; only a DONE entry (zero shadow) holds it
            if (state_q != DONE) expired_q <= 1'b0;
`endif
            case (state_q)
                IDLE, PAUSE: begin
                    if (!stop && start && cnt_q != TIME_ZERO) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else begin
                        presc_q <= presc_d;
                        if (tick && hit_zero) begin
                            expired_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
                            if (shadow_q != TIME_ZERO) begin
                                cnt_q <= shadow_q;
                            end else begin
                                cnt_q     <= TIME_ZERO;
                                state_q   <= DONE;
                                running_q <= 1'b0;
                            end
`else
                            cnt_q     <= TIME_ZERO;
                            state_q   <= DONE;
                            running_q <= 1'b0;
`endif
                        end else if (tick) begin
                            cnt_q <= dec_d;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign time_bcd = cnt_q;
    assign running  = running_q;
    assign expired  = expired_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed checks of the countdown timer with PRESCALE=4
module tb_bcd_countdown_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] time_bcd;
    logic        running;
    logic        expired;
    int          total = 0;
    int          bad = 0;

    bcd_countdown_timer #(.PRESCALE(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .preset  (preset),
        .start   (start),
        .stop    (stop),
        .time_bcd(time_bcd),
        .running (running),
        .expired (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        preset = v;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst_time", time_bcd, 16'h0000);
        chk("rst_run", {15'd0, running}, 16'd0);
        chk("rst_exp", {15'd0, expired}, 16'd0);

        do_load(16'h0003);
        chk("t1_load", time_bcd, 16'h0003);
        do_start();
        chk("t1_run", {15'd0, running}, 16'd1);
        step(3);
        chk("t1_c3", time_bcd, 16'h0003);
        step(1);
        chk("t1_c4", time_bcd, 16'h0002);
        step(4);
        chk("t1_c8", time_bcd, 16'h0001);
        step(3);
        chk("t1_c11", time_bcd, 16'h0001);
        step(1);
        chk("t1_exp", {15'd0, expired}, 16'd1);
`ifdef AUTO_RELOAD_EN
        chk("t1_reload", time_bcd, 16'h0003);
        chk("t1_runon", {15'd0, running}, 16'd1);
        step(1);
        chk("t1_pulse", {15'd0, expired}, 16'd0);
`else
        chk("t1_zero", time_bcd, 16'h0000);
        chk("t1_stopped", {15'd0, running}, 16'd0);
        step(5);
        do_start();
        chk("t1_done_start", {15'd0, running}, 16'd0);
        chk("t1_done_hold", {15'd0, expired}, 16'd1);
        chk("t1_done_time", time_bcd, 16'h0000);
`endif

        do_load(16'h0100);
        chk("t2_loadclr", {15'd0, expired}, 16'd0);
        do_start();
        step(4);
        chk("t2_0100", time_bcd, 16'h0099);
        do_load(16'h1000);
        do_start();
        step(4);
        chk("t2_1000", time_bcd, 16'h0999);

        do_load(16'h0050);
        do_start();
        step(4);
        chk("t3_first", time_bcd, 16'h0049);
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t3_paused", {15'd0, running}, 16'd0);
        step(20);
        chk("t3_hold", time_bcd, 16'h0049);
        do_start();
        chk("t3_resume", {15'd0, running}, 16'd1);
        step(1);
        chk("t3_r1", time_bcd, 16'h0049);
        step(1);
        chk("t3_r2", time_bcd, 16'h0048);

        do_load(16'h0005);
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        chk("t4_both", {15'd0, running}, 16'd0);
        do_load(16'h0000);
        do_start();
        chk("t4_zero", {15'd0, running}, 16'd0);
        do_load(16'hFA3C);
        chk("t4_sat", time_bcd, 16'h9939);

        do_load(16'h0005);
        do_start();
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("t5_time", time_bcd, 16'h0000);
        chk("t5_run", {15'd0, running}, 16'd0);
        chk("t5_exp", {15'd0, expired}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(10);
        chk("t5_after", {15'd0, expired | running}, 16'd0);

`ifdef AUTO_RELOAD_EN
        do_load(16'h0002);
        do_start();
        step(4);
        chk("t6_c4", time_bcd, 16'h0001);
        chk("t6_noexp", {15'd0, expired}, 16'd0);
        step(4);
        chk("t6_c8", time_bcd, 16'h0002);
        chk("t6_pulse8", {15'd0, expired}, 16'd1);
        chk("t6_run8", {15'd0, running}, 16'd1);
        step(1);
        chk("t6_c9", {15'd0, expired}, 16'd0);
        step(7);
        chk("t6_pulse16", {15'd0, expired}, 16'd1);
        chk("t6_c16", time_bcd, 16'h0002);
        do_load(16'h0033);
        chk("t6_ld_run", {15'd0, running}, 16'd0);
        chk("t6_ld_time", time_bcd, 16'h0033);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
